// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory for the MIPS fetch stage: zero-fills after reset,
// takes a program over a valid/ready stream from word 0, then serves 1-cycle fetches.
module inst_mem_loadable #(
    parameter int                DEPTH      = 32,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [DATA_W-1:0] FAULT_INST = 32'hB4221820
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    input  logic [DATA_W-1:0]       load_data,
    input  logic                    load_last,
    output logic                    load_ready,
    output logic                    load_done,
    output logic [$clog2(DEPTH):0]  load_count,
    output logic                    load_overflow,
    input  logic                    fetch_req,
    input  logic [ADDR_W-1:0]       fetch_addr,
    input  logic                    fetch_stall,
    output logic [DATA_W-1:0]       inst_out,
    output logic                    inst_valid,
    output logic                    inst_fault
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    logic               load_xfer;
    logic               load_full;

    logic [AW-1:0]      fetch_idx;
    logic               fetch_bad;
    logic               fetch_fire;
    logic               fetch_idle;

    logic [DATA_W-1:0]  rd_q;
    logic               sel_fault_q;
    logic               valid_q;
    logic               fault_q;

    assign load_full  = (cnt_q == FULL_CNT);
    assign load_ready = (state_q == ST_LOAD) && !load_full;
    assign load_xfer  = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Single write port shared by the zero-fill sweep and the program loader.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    ptr_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_xfer) begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q[AW-1:0];
                    mem_wdata = load_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end else if (load_full && load_valid) begin
                    // Array is full: drop the word but still honour end-of-program.
                    ovf_d = 1'b1;
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_idx  = fetch_addr[AW+1:2];
    assign fetch_bad  = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[ADDR_W-1:AW+2]);
    assign fetch_fire = (state_q == ST_RUN) && fetch_req && !fetch_stall;
    assign fetch_idle = (state_q == ST_RUN) && !fetch_req && !fetch_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else if (fetch_fire) begin
            rd_q <= mem[fetch_idx];
        end
    end

    // The fault select is held separately so inst_out keeps FAULT_INST after an idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_fault_q <= 1'b0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else if (fetch_fire) begin
            sel_fault_q <= fetch_bad;
            valid_q     <= 1'b1;
            fault_q     <= fetch_bad;
        end else if (fetch_idle) begin
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
        end
    end

    assign inst_out      = sel_fault_q ? FAULT_INST : rd_q;
    assign inst_valid    = valid_q;
    assign inst_fault    = fault_q;
    assign load_done     = (state_q == ST_RUN);
    assign load_count    = cnt_q;
    assign load_overflow = ovf_q;

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
- Parametrised, clocked instruction memory for the MIPS fetch stage.
- Replaces hard-coded program contents with a runtime load port: a valid/ready word stream written sequentially from address 0.
- After a reset it zero-fills the array, accepts a program, then serves fetches with fixed one-cycle read latency.
- Supports stall hold and flags out-of-range or misaligned fetches.

Parameters:
- DEPTH, 32, number of instruction words; must be a power of two, at least 4.
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 32, width of the byte address on fetch_addr.
- FAULT_INST, 32'hB4221820, word returned on a faulting fetch (HALT encoding).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- load_valid  in  1  load word present.
- load_data  in  DATA_W  load word.
- load_last  in  1  qualifies the final word of the program.
- load_ready  out  1  block accepts a load word this cycle.
- load_done  out  1  program loaded; fetch port is live.
- load_count  out  clog2(DEPTH)+1  number of words written so far.
- load_overflow  out  1  sticky; a word was offered beyond DEPTH.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address of the fetch.
- fetch_stall  in  1  freeze the fetch output.
- inst_out  out  DATA_W  fetched instruction.
- inst_valid  out  1  inst_out holds the response to a request.
- inst_fault  out  1  response was out of range or misaligned.

Behaviour:
- FSM states: CLEAR, LOAD, RUN. Reset forces CLEAR from any state, including mid-load or mid-fetch.
- Reset values: load_ready=0, load_done=0, load_count=0, load_overflow=0, inst_out=0, inst_valid=0, inst_fault=0; internal pointer=0.
- CLEAR:
  - Writes 0 to mem[ptr] each cycle and increments ptr.
  - After writing mem[DEPTH-1] (DEPTH cycles), sets ptr=0 and moves to LOAD.
  - load_ready=0 throughout.
- LOAD:
  - load_ready=1 while load_count<DEPTH.
  - Handshake: a transfer occurs when load_valid && load_ready. It writes mem[load_count]=load_data and increments load_count.
  - A transfer with load_last=1 moves the FSM to RUN on the next cycle.
  - At load_count==DEPTH: load_ready=0. If load_valid=1, set load_overflow; the word is dropped. If load_last=1 is also present, still move to RUN.
  - load_last with load_valid=0 is ignored.
  - An empty program is impossible; at least one word must transfer.
- RUN:
  - load_done=1 and load_ready=0. Load inputs are ignored; load_overflow is never newly set.
  - Word index = fetch_addr >> 2.
  - Fault when fetch_addr[1:0]!=0 or the word index is >= DEPTH, including any set upper address bits.
  - Fetch, when fetch_req=1 and fetch_stall=0:
    - Next cycle: inst_valid=1.
    - inst_out = mem[index], or FAULT_INST if faulting.
    - inst_fault = the fault condition.
  - fetch_req=0 and fetch_stall=0: next cycle inst_valid=0 and inst_fault=0; inst_out holds its last value.
  - fetch_stall=1: inst_out, inst_valid and inst_fault all hold, even if fetch_req=1. Stall wins; that request is dropped.
- Latency: exactly 1 cycle from an accepted request to response. Back-to-back requests are supported every cycle.
- Fetches in CLEAR or LOAD are ignored; inst_valid stays 0.
- The memory array is written only by CLEAR and LOAD; RUN never writes it.
- Words not loaded read as 0 (NOP, SLL R0,R0,0).

Test Plan:
- Reset, then hold load_valid=0 -> load_ready rises exactly 32 cycles after reset deassert. A later fetch of address 0x40 returns 0.
- Load 0x0C000004, 0x8C010004, 0xB4221820 (last on word 3); fetch addresses 0, 4, 8 back-to-back -> same words, one per cycle, each 1 cycle after its request. load_count=3, load_done=1.
- In RUN, fetch addresses 0x80 and 0x06 -> inst_out=0xB4221820 with inst_fault=1, inst_valid=1 for each.
- Fetch address 4, then assert fetch_stall for 3 cycles while fetch_req=1 with address 8 -> inst_out stays 0x8C010004. After the stall is released, the address-8 response arrives one cycle later.
- Stream 33 words with load_last on word 33 -> load_ready drops after word 32, load_overflow=1, FSM enters RUN. A fetch of address 0x7C returns word 32.
- Assert reset mid-load after 2 words -> all outputs return to reset values; CLEAR reruns. A fetch of address 0 after a one-word reload of 0x00001020 returns 0x00001020; address 4 returns 0.
